// File: rtl/and_delay_pkg.sv
// Shared helpers for the AND delay line: delay-width sizing, delay clamping
// and the legal parameter window.
package and_delay_pkg;

    function automatic int dly_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Zero is meaningless as a delay, so it folds up to the one-stage minimum.
    function automatic int unsigned clamp_dly(input int unsigned v, input int unsigned depth);
        if (v == 0) begin
            return 1;
        end else if (v > depth) begin
            return depth;
        end else begin
            return v;
        end
    endfunction

    function automatic bit dly_params_ok(input int depth, input int rst_dly);
        return (depth >= 2) && (rst_dly >= 1) && (rst_dly <= depth);
    endfunction

endpackage

// File: rtl/and_delay_chan.sv
// One AND channel: transport shift line with tapped output plus inertial filter.
// Latency i_dly cycles on both views; no backpressure, accepts a sample every cycle.
module and_delay_chan
    import and_delay_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = dly_w(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_a,
    input  logic          i_b,
    input  logic [DW-1:0] i_dly,
    output logic          o_out,
    output logic          o_out1,
    output logic          o_glitch
);
    localparam int TW = $clog2(DEPTH);

    logic             w_y;
    logic [TW-1:0]    w_tap;
    logic             w_hold_done;
    logic [DEPTH-1:0] r_line;
    logic [DW-1:0]    r_cnt;
    logic             r_out1;
    logic             r_glitch;

    assign w_y   = i_a & i_b;
    // i_dly is always in 1..DEPTH, so dly-1 indexes a valid stage.
    assign w_tap = TW'(i_dly - DW'(1));
    assign o_out = r_line[w_tap];

    assign w_hold_done = ({1'b0, r_cnt} + (DW+1)'(1)) >= {1'b0, i_dly};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_line   <= '0;
            r_cnt    <= '0;
            r_out1   <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_line   <= {r_line[DEPTH-2:0], w_y};
            r_glitch <= 1'b0;
            if (w_y == r_out1) begin
                // Returning to the old level before the hold time means a pulse was dropped.
                r_cnt    <= '0;
                r_glitch <= (r_cnt != '0);
            end else if (w_hold_done) begin
                r_out1 <= w_y;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + DW'(1);
            end
        end
    end

    assign o_out1   = r_out1;
    assign o_glitch = r_glitch;

endmodule

// File: rtl/and_delay_line.sv
// WIDTH-channel AND with programmable transport and inertial delay, shared delay register.
// Latency dly cycles (1..DEPTH); no backpressure, new dly takes effect on the load edge.
module and_delay_line
    import and_delay_pkg::*;
#(
    parameter int   WIDTH   = 4,
    parameter int   DEPTH   = 8,
    parameter int   RST_DLY = 1,
    localparam int  DW      = dly_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             dly_ld,
    input  logic [DW-1:0]    dly_in,
    output logic [DW-1:0]    dly,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] glitch
);
    logic [DW-1:0] r_dly;
    logic [DW-1:0] w_dly_clamped;

    assign w_dly_clamped = DW'(clamp_dly(32'(dly_in), 32'(DEPTH)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly <= DW'(RST_DLY);
        end else if (dly_ld) begin
            r_dly <= w_dly_clamped;
        end
    end

    assign dly = r_dly;

    always_ff @(posedge clk) begin : p_param_chk
        assert (dly_params_ok(DEPTH, RST_DLY));
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        and_delay_chan #(
            .DEPTH (DEPTH),
            .DW    (DW)
        ) u_chan (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_a      (a[i]),
            .i_b      (b[i]),
            .i_dly    (r_dly),
            .o_out    (out[i]),
            .o_out1   (out1[i]),
            .o_glitch (glitch[i])
        );
    end

endmodule
